rx_word_align: RTL and testbench



---
 rtl/rx_word_align_pkg.sv | 25 ++
 rtl/rx_word_align_word_rot_sel.sv | 19 +
 rtl/rx_word_align.sv | 153 +++++++++++++++
 tb/tb_rx_word_align.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/rx_word_align_pkg.sv
// Shared types and constants for the RX word aligner: word width from the
// serializer tree depth, the alignment FSM states and the training pattern.
`ifndef SERDES_STAGES
`define SERDES_STAGES 2
`endif

package rx_word_align_pkg;

  localparam int STAGES_DEF = `SERDES_STAGES;
  localparam int W_DEF      = 2 ** STAGES_DEF;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SEARCH  = 2'd1,
    CONFIRM = 2'd2,
    LOCKED  = 2'd3
  } state_e;

  // Lower w/2 bits set, upper w/2 clear: the only rotation of this word that
  // equals itself is the identity, so the match offset is unambiguous.
  function automatic logic [63:0] gen_pattern(input int unsigned w);
    return (64'd1 << (w / 2)) - 64'd1;
  endfunction

endpackage

// File: rtl/rx_word_align_word_rot_sel.sv
// Picks one W-bit window out of two concatenated raw words at a given bit
// offset; bit 0 of the result is the earliest bit on the wire.
module rx_word_align_word_rot_sel
  import rx_word_align_pkg::*;
#(
  parameter int W  = W_DEF,
  parameter int SW = 2
) (
  input  logic [2*W-1:0] cat_i,
  input  logic [SW-1:0]  sel_i,
  output logic [W-1:0]   win_o
);

  logic [2*W-1:0] shifted;

  assign shifted = cat_i >> sel_i;
  assign win_o   = shifted[W-1:0];

endmodule

// File: rtl/rx_word_align.sv
// Finds the TX word boundary in the raw deserializer stream from a training
// pattern and emits re-aligned words once the offset has been confirmed.
module rx_word_align
  import rx_word_align_pkg::*;
#(
  parameter int STAGES     = STAGES_DEF,
  parameter int LOCK_COUNT = 8,
  localparam int W  = 2 ** STAGES,
  localparam int SW = (W > 1) ? $clog2(W) : 1,
  localparam int CW = $clog2(LOCK_COUNT + 1)
) (
  input  logic          clk,
  input  logic          rstb,
  input  logic [W-1:0]  din,
  input  logic          din_valid,
  input  logic          train_en,
  input  logic          relock,
  output logic [W-1:0]  dout,
  output logic          dout_valid,
  output logic          locked,
  output logic [SW-1:0] shift,
  output logic          err
);

  localparam logic [W-1:0] PATTERN = W'(gen_pattern(W));

  state_e        state_q;
  logic [W-1:0]  prev_q;
  logic          prev_vld_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          cnt_done;
  logic [W-1:0]  dout_q;
  logic          dout_valid_q;
  logic          locked_q;
  logic [SW-1:0] shift_q;
  logic          err_q;

  logic [2*W-1:0] cat;
  logic [W-1:0]   match;
  logic [W-1:0]   win_sel;
  logic           match_sel;
  logic           hit_any;
  logic [SW-1:0]  hit_k;

  assign cat = {din, prev_q};

  // Every candidate offset is evaluated in parallel against the pattern.
  for (genvar k = 0; k < W; k++) begin : g_cand
    logic [W-1:0] win_k;
    rx_word_align_word_rot_sel #(.W(W), .SW(SW)) u_cand (
      .cat_i (cat),
      .sel_i (SW'(k)),
      .win_o (win_k)
    );
    assign match[k] = prev_vld_q && (win_k == PATTERN);
  end

  rx_word_align_word_rot_sel #(.W(W), .SW(SW)) u_out_sel (
    .cat_i (cat),
    .sel_i (shift_q),
    .win_o (win_sel)
  );

  assign match_sel = match[shift_q];

  always_comb begin
    hit_any = |match;
    hit_k   = '0;
    for (int k = W - 1; k >= 0; k--) begin
      if (match[k]) hit_k = SW'(k);
    end
  end

  // cnt only reaches LOCK_COUNT on the locking edge, so cnt_d never wraps.
  assign cnt_d    = cnt_q + 1'b1;
  assign cnt_done = (cnt_d == CW'(LOCK_COUNT));

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q      <= IDLE;
      prev_q       <= '0;
      prev_vld_q   <= 1'b0;
      cnt_q        <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      locked_q     <= 1'b0;
      shift_q      <= '0;
      err_q        <= 1'b0;
    end else begin
      dout_valid_q <= 1'b0;
      if (relock) begin
        state_q    <= train_en ? SEARCH : IDLE;
        locked_q   <= 1'b0;
        cnt_q      <= '0;
        err_q      <= 1'b0;
        prev_vld_q <= 1'b0;
        if (din_valid) prev_q <= din;
      end else if (din_valid) begin
        prev_q     <= din;
        prev_vld_q <= 1'b1;
        case (state_q)
          IDLE: begin
            locked_q <= 1'b0;
            if (train_en) state_q <= SEARCH;
          end
          SEARCH: begin
            if (!train_en) begin
              state_q <= IDLE;
            end else if (hit_any) begin
              shift_q <= hit_k;
              cnt_q   <= CW'(1);
              if (LOCK_COUNT == 1) begin
                state_q  <= LOCKED;
                locked_q <= 1'b1;
              end else begin
                state_q <= CONFIRM;
              end
            end
          end
          CONFIRM: begin
            if (!train_en) begin
              state_q <= IDLE;
              cnt_q   <= '0;
            end else if (match_sel) begin
              cnt_q <= cnt_d;
              if (cnt_done) begin
                state_q  <= LOCKED;
                locked_q <= 1'b1;
              end
            end else begin
              cnt_q   <= '0;
              state_q <= SEARCH;
            end
          end
          LOCKED: begin
            dout_q       <= win_sel;
            dout_valid_q <= 1'b1;
            if (train_en && !match_sel) err_q <= 1'b1;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign locked     = locked_q;
  assign shift      = shift_q;
  assign err        = err_q;

endmodule

// File: tb/tb_rx_word_align.sv
// Scoreboard bench for rx_word_align with W=4, LOCK_COUNT=4, pattern 4'b0011.
module tb_rx_word_align;

  logic       clk = 1'b0;
  logic       rstb;
  logic [3:0] din;
  logic       din_valid;
  logic       train_en;
  logic       relock;
  logic [3:0] dout;
  logic       dout_valid;
  logic       locked;
  logic [1:0] shift;
  logic       err;

  int n_vec = 0;
  int n_err = 0;
  logic [3:0] exp_q[$];

  always #5 clk = ~clk;

  rx_word_align #(.STAGES(2), .LOCK_COUNT(4)) dut (
    .clk        (clk),
    .rstb       (rstb),
    .din        (din),
    .din_valid  (din_valid),
    .train_en   (train_en),
    .relock     (relock),
    .dout       (dout),
    .dout_valid (dout_valid),
    .locked     (locked),
    .shift      (shift),
    .err        (err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", name, act, req);
    end
  endtask

  task automatic cyc(input logic [3:0] d, input logic v);
    din       = d;
    din_valid = v;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rstb = 1'b0;
    #2;
    rstb = 1'b1;
  endtask

  // Monitor: every presented aligned word must be the next expected one.
  always @(negedge clk) begin
    if (rstb && dout_valid) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL dout_unexpected: got %0h, want no output", dout);
      end else begin
        check("dout", 32'(dout), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want $finish");
    $fatal(1, "watchdog expired");
  end

  // Aligned TX words: five pattern words, eight data words, one filler whose
  // bit 0 only completes the last raw word.
  logic [3:0] a_seq [14] = '{4'h3, 4'h3, 4'h3, 4'h3, 4'h3,
                             4'hA, 4'h5, 4'hC, 4'h3, 4'hF, 4'h0, 4'h6, 4'h9,
                             4'h0};

  initial begin
    rstb = 1'b0; din = '0; din_valid = 1'b0; train_en = 1'b0; relock = 1'b0;
    #2;
    check("rst_locked", 32'(locked), 0);
    check("rst_dout_valid", 32'(dout_valid), 0);
    check("rst_dout", 32'(dout), 0);
    check("rst_shift", 32'(shift), 0);
    check("rst_err", 32'(err), 0);
    #1 rstb = 1'b1;

    // Rotation 3: raw word j carries aligned[j][3:1] then aligned[j+1][0].
    for (int j = 0; j < 13; j++) begin
      train_en = (j < 5);
      if (j >= 5) exp_q.push_back(a_seq[j]);
      cyc({a_seq[j+1][0], a_seq[j][3:1]}, 1'b1);
      if (j == 3) check("A_prelock", 32'(locked), 0);
      if (j == 4) begin
        check("A_locked", 32'(locked), 1);
        check("A_shift", 32'(shift), 3);
      end
    end
    cyc(4'h0, 1'b0);
    check("A_gap_valid", 32'(dout_valid), 0);
    check("A_dout_hold", 32'(dout), 32'h9);
    check("A_err", 32'(err), 0);

    // Break during confirm.
    pulse_reset();
    train_en = 1'b1;
    for (int i = 0; i < 3; i++) cyc(4'b1001, 1'b1);
    cyc(4'b1111, 1'b1);
    check("B_break_locked", 32'(locked), 0);
    for (int i = 0; i < 4; i++) begin
      cyc(4'b1001, 1'b1);
      if (i == 2) check("B_prelock", 32'(locked), 0);
      if (i == 3) begin
        check("B_locked", 32'(locked), 1);
        check("B_shift", 32'(shift), 3);
      end
    end

    // din_valid gaps between pattern words; garbage on gap cycles is ignored.
    pulse_reset();
    train_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc(4'b1001, 1'b1);
      if (i == 3) check("C_prelock", 32'(locked), 0);
      if (i == 4) begin
        check("C_locked", 32'(locked), 1);
        check("C_shift", 32'(shift), 3);
      end
      if (i < 4) begin
        cyc(4'b1111, 1'b0);
        if (i == 1) cyc(4'b1111, 1'b0);
        check("C_gap_locked", 32'(locked), 0);
      end
    end
    exp_q.push_back(4'b0011);
    cyc(4'b1001, 1'b1);
    cyc(4'b1111, 1'b0);
    check("C_gap_valid", 32'(dout_valid), 0);
    check("C_dout_hold", 32'(dout), 32'h3);

    // Pattern violation while locked and training, then relock.
    exp_q.push_back(4'b1011);
    cyc(4'b0101, 1'b1);
    check("D_err_set", 32'(err), 1);
    exp_q.push_back(4'b0010);
    cyc(4'b1001, 1'b1);
    check("D_err_sticky", 32'(err), 1);
    relock = 1'b1;
    cyc(4'b1111, 1'b0);
    relock = 1'b0;
    check("D_relock_locked", 32'(locked), 0);
    check("D_relock_err", 32'(err), 0);
    check("D_relock_valid", 32'(dout_valid), 0);
    for (int i = 0; i < 5; i++) begin
      cyc(4'b0110, 1'b1);
      if (i == 3) check("D_prelock", 32'(locked), 0);
      if (i == 4) begin
        check("D_locked", 32'(locked), 1);
        check("D_shift", 32'(shift), 1);
      end
    end

    // Async reset between edges while locked with err set.
    exp_q.push_back(4'b1011);
    cyc(4'b1111, 1'b1);
    check("E_err_set", 32'(err), 1);
    check("E_valid_pre", 32'(dout_valid), 1);
    @(negedge clk);
    #1;
    rstb = 1'b0;
    #1;
    check("E_locked", 32'(locked), 0);
    check("E_dout_valid", 32'(dout_valid), 0);
    check("E_dout", 32'(dout), 0);
    check("E_shift", 32'(shift), 0);
    check("E_err", 32'(err), 0);
    #2 rstb = 1'b1;
    din_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("queue_drain", 32'(exp_q.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
